// File: rtl/irq_encoder8x3.sv
`default_nettype none
// ============================================================================
// irq_encoder8x3 : edge-captured 8-to-3 request encoder with valid/ack handshake
// Optional macro IRQ_ENC_OVF_EN adds sticky lost-event flags (ovf/ovf_clr).
// Revision 1.0
// ============================================================================
module irq_encoder8x3 #(
  parameter int PRIO_HIGH_FIRST = 1,
  parameter int GAP_CYCLES      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       ack,
`ifdef IRQ_ENC_OVF_EN
  input  logic       ovf_clr,
  output logic [7:0] ovf,
`else
`endif
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pending,
  output logic       empty
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  localparam logic [1:0] GAP_LOAD = 2'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] req_d_q;
  logic [7:0] pending_q, pending_d;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic [1:0] gap_q, gap_d;
  logic [7:0] rise, clr_vec, elig;

  function automatic logic [2:0] prio_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    // Scan toward the winning end so the last hit is the highest priority.
    if (PRIO_HIGH_FIRST != 0) begin
      for (int i = 0; i < 8; i++) if (v[i]) idx = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--) if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_comb begin
    rise    = req & ~req_d_q;
    clr_vec = 8'h00;
    if (state_q == PRESENT && ack) clr_vec = 8'h01 << code_q;
    pending_d = (pending_q & ~clr_vec) | rise;
    elig      = pending_q & ~mask;

    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (elig != 8'h00) begin
          code_d  = prio_index(elig);
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          valid_d = 1'b0;
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == 2'd0) state_d = IDLE;
        else               gap_d   = gap_q - 2'd1;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

`ifdef IRQ_ENC_OVF_EN
  logic [7:0] ovf_q, ovf_d;

  // A rise on a bit that stays pending this cycle is a lost event.
  always_comb begin
    ovf_d = (ovf_clr ? 8'h00 : ovf_q) | (rise & pending_q & ~clr_vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 8'h00;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_d_q   <= 8'h00;
      pending_q <= 8'h00;
      code_q    <= 3'd0;
      valid_q   <= 1'b0;
      gap_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      req_d_q   <= req;
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      gap_q     <= gap_d;
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  assign empty   = (pending_q == 8'h00);

endmodule
`default_nettype wire

// File: tb/tb_irq_encoder8x3.sv
`default_nettype none
// ============================================================================
// tb_irq_encoder8x3 : directed + randomized bench with a cycle-level reference
// Revision 1.0
// ============================================================================
module tb_irq_encoder8x3;

  localparam int PHF = 1;
  localparam int GAP = 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req   = 8'h00;
  logic [7:0] mask  = 8'h00;
  logic       ack   = 1'b0;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  logic       empty;
`ifdef IRQ_ENC_OVF_EN
  logic       ovf_clr = 1'b0;
  logic [7:0] ovf;
`endif

  int checks = 0;
  int errors = 0;
  int last_wait = 0;

  // Reference state: pending set, presented code, and the first edge at
  // which a new arbitration is allowed after an acknowledge.
  bit [7:0] m_pend, m_prev, m_ovf;
  bit       m_valid;
  int       m_code;
  longint   cyc, m_hold;

  irq_encoder8x3 #(.PRIO_HIGH_FIRST(PHF), .GAP_CYCLES(GAP)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mask    (mask),
    .ack     (ack),
`ifdef IRQ_ENC_OVF_EN
    .ovf_clr (ovf_clr),
    .ovf     (ovf),
`endif
    .code    (code),
    .valid   (valid),
    .pending (pending),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int best(input bit [7:0] v);
    if (PHF != 0) begin
      for (int i = 7; i >= 0; i--) if (v[i]) return i;
    end else begin
      for (int i = 0; i < 8; i++) if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = 8'h00; m_prev = 8'h00; m_ovf = 8'h00;
    m_valid = 1'b0; m_code = 0; m_hold = 0; cyc = 0;
  endtask

  task automatic model_edge(input bit [7:0] r, input bit [7:0] mk, input bit a, input bit oc);
    bit [7:0] clr;
    bit [7:0] rise;
    clr = 8'h00;
    if (m_valid && a) begin
      clr[m_code] = 1'b1;
      m_valid = 1'b0;
      m_hold = cyc + GAP + 1;
    end else if (!m_valid && cyc >= m_hold && (m_pend & ~mk) != 8'h00) begin
      m_code = best(m_pend & ~mk);
      m_valid = 1'b1;
    end
    rise   = r & ~m_prev;
    m_ovf  = (oc ? 8'h00 : m_ovf) | (rise & m_pend & ~clr);
    m_pend = (m_pend & ~clr) | rise;
    m_prev = r;
    cyc++;
  endtask

  task automatic compare();
    chk("valid",   8'(valid),   8'(m_valid));
    chk("code",    8'(code),    8'(m_code));
    chk("pending", pending,     m_pend);
    chk("empty",   8'(empty),   8'(m_pend == 8'h00));
`ifdef IRQ_ENC_OVF_EN
    chk("ovf",     ovf,         m_ovf);
`endif
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit [7:0] r, input bit [7:0] mk, input bit a, input bit oc);
    req = r; mask = mk; ack = a;
`ifdef IRQ_ENC_OVF_EN
    ovf_clr = oc;
`endif
    @(posedge clk);
    model_edge(r, mk, a, oc);
    @(negedge clk);
    compare();
  endtask

  // Reset lands mid low-phase so its effect is seen without any clock edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid",   8'(valid), 8'h00);
    chk("rst_pending", pending,   8'h00);
    chk("rst_empty",   8'(empty), 8'h01);
    chk("rst_code",    8'(code),  8'h00);
    model_reset();
    req = 8'h00; ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input bit [7:0] mk);
    last_wait = 0;
    while (!valid && last_wait < 12) begin
      step(8'h00, mk, 1'b0, 1'b0);
      last_wait++;
    end
    chk("wait_valid", 8'(valid), 8'h01);
  endtask

  task automatic serve(input bit [7:0] mk, input int exp_code);
    wait_valid(mk);
    chk("serve_code", 8'(code), 8'(exp_code));
    step(8'h00, mk, 1'b1, 1'b0);
  endtask

  initial begin
    int services;
    @(negedge clk);
    do_reset();

    // Single request: valid two edges after the rising sample.
    step(8'h20, 8'h00, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0);
    chk("single_valid", 8'(valid), 8'h01);
    chk("single_code",  8'(code),  8'h05);
    step(8'h00, 8'h00, 1'b1, 1'b0);
    chk("single_clear", pending, 8'h00);
    chk("single_empty", 8'(empty), 8'h01);

    // Priority order with fixed spacing between acks.
    step(8'h92, 8'h00, 1'b0, 1'b0);
    serve(8'h00, (PHF != 0) ? 7 : 1);
    serve(8'h00, 4);
    chk("spacing", 8'(last_wait), 8'(GAP + 1));
    serve(8'h00, (PHF != 0) ? 1 : 7);
    chk("spacing2", 8'(last_wait), 8'(GAP + 1));

    // Mask and freeze.
    step(8'h44, 8'h40, 1'b0, 1'b0);
    wait_valid(8'h40);
    chk("mask_code", 8'(code), 8'h02);
    step(8'h80, 8'h44, 1'b0, 1'b0);
    step(8'h00, 8'h44, 1'b0, 1'b0);
    chk("freeze_code",  8'(code),  8'h02);
    chk("freeze_valid", 8'(valid), 8'h01);
    step(8'h00, 8'h44, 1'b1, 1'b0);
    serve(8'h00, (PHF != 0) ? 7 : 6);
    serve(8'h00, (PHF != 0) ? 6 : 7);

    // New rise on the bit being acknowledged keeps it pending.
    step(8'h08, 8'h00, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0);
    wait_valid(8'h00);
    step(8'h08, 8'h00, 1'b1, 1'b0);
    chk("setwins_pend", pending, 8'h08);
    serve(8'h00, 3);
    chk("setwins_empty", 8'(empty), 8'h01);

    // All masked: pending accumulates, no service.
    step(8'h0F, 8'hFF, 1'b0, 1'b0);
    step(8'h30, 8'hFF, 1'b0, 1'b0);
    step(8'h00, 8'hFF, 1'b0, 1'b0);
    chk("allmask_valid", 8'(valid), 8'h00);
    chk("allmask_pend",  pending,   8'h3F);

    // Reset while presenting.
    wait_valid(8'h00);
    do_reset();

    // Full pending: eight handshakes in strict priority order.
    step(8'hFF, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) serve(8'h00, (PHF != 0) ? 7 - k : k);
    chk("ff_empty", 8'(empty), 8'h01);

    // Duplicate edge on an unserved bit.
    do_reset();
    step(8'h01, 8'h00, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0);
    step(8'h01, 8'h00, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0);
`ifdef IRQ_ENC_OVF_EN
    chk("ovf_set", ovf, 8'h01);
    step(8'h00, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", ovf, 8'h00);
`endif
    serve(8'h00, 0);
    services = 0;
    for (int k = 0; k < 6; k++) begin
      step(8'h00, 8'h00, 1'b0, 1'b0);
      if (valid) services++;
    end
    chk("dup_merged", 8'(services), 8'h00);

    // Randomized traffic against the reference.
    for (int k = 0; k < 400; k++) begin
      bit [7:0] r, mk;
      r  = 8'($urandom) & 8'($urandom);
      mk = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step(r, mk, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      if (k == 200) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
